// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: streams the eight words of a 2-read-port register file (R0..R7) out over a
// valid/ready interface, one register pair per fetch. An optional checksum word (the sum
// of the eight words, modulo 2^W_width) follows R7.
//
// Ports
//   CLK           system clock, rising edge
//   RST           synchronous active-high reset
//   start_i       single-cycle dump request, honoured only when idle
//   srcRegA_o     register file read select A (even register of the current pair)
//   srcRegB_o     register file read select B (odd register of the current pair)
//   busA_i        register file read data A (combinational)
//   busB_i        register file read data B (combinational)
//   dout_o        streamed word
//   dout_valid_o  dout_o holds a valid word
//   dout_ready_i  downstream accepts the word
//   dout_last_o   final word of the dump
//   busy_o        dump in progress
//   done_o        one-cycle pulse when a dump completes
module reg_dump_ctrl #(
    parameter int unsigned W_width     = 32,
    parameter bit          CHECKSUM_EN = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start_i,
    output logic [2:0]         srcRegA_o,
    output logic [2:0]         srcRegB_o,
    input  logic [W_width-1:0] busA_i,
    input  logic [W_width-1:0] busB_i,
    output logic [W_width-1:0] dout_o,
    output logic               dout_valid_o,
    input  logic               dout_ready_i,
    output logic               dout_last_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSendA,
        StSendB,
        StSendSum,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           ptr_q, ptr_d;
    logic [W_width-1:0]   bufa_q, bufa_d;
    logic [W_width-1:0]   bufb_q, bufb_d;
    logic [W_width-1:0]   sum_q, sum_d;
    logic [W_width-1:0]   dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 handshake;

    // valid is a flop, so the handshake never creates a ready->valid combinational path.
    assign handshake = valid_q & dout_ready_i;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        bufa_d  = bufa_q;
        bufb_d  = bufb_q;
        sum_d   = sum_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFetch;
                    ptr_d   = 3'd0;
                    sum_d   = '0;
                end
            end
            StFetch: begin
                bufa_d  = busA_i;
                bufb_d  = busB_i;
                sum_d   = sum_q + busA_i + busB_i;
                state_d = StSendA;
            end
            StSendA: begin
                if (handshake) begin
                    state_d = StSendB;
                end
            end
            StSendB: begin
                if (handshake) begin
                    if (ptr_q != 3'd6) begin
                        ptr_d   = ptr_q + 3'd2;
                        state_d = StFetch;
                    end else begin
                        state_d = CHECKSUM_EN ? StSendSum : StDone;
                    end
                end
            end
            StSendSum: begin
                if (handshake) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Park the pointer so the idle selects read R0/R1.
                state_d = StIdle;
                ptr_d   = 3'd0;
            end
            default: begin
                state_d = StIdle;
                ptr_d   = 3'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they come straight from flops.
    always_comb begin
        dout_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;

        case (state_d)
            StSendA: begin
                dout_d  = bufa_d;
                valid_d = 1'b1;
            end
            StSendB: begin
                dout_d  = bufb_d;
                valid_d = 1'b1;
                last_d  = !CHECKSUM_EN && (ptr_d == 3'd6);
            end
            StSendSum: begin
                dout_d  = sum_d;
                valid_d = 1'b1;
                last_d  = 1'b1;
            end
            default: begin
                dout_d  = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            ptr_q   <= 3'd0;
            bufa_q  <= '0;
            bufb_q  <= '0;
            sum_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bufa_q  <= bufa_d;
            bufb_q  <= bufb_d;
            sum_q   <= sum_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign srcRegA_o    = ptr_q;
    assign srcRegB_o    = ptr_q + 3'd1;
    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign dout_last_o  = last_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
